// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the two-requester word-to-byte memory arbiter.
package mem_arb_pkg;

  localparam int NBYTES = 4;
  localparam int CNT_W  = $clog2(NBYTES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_WR    = 3'd2,
    ST_RD    = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Two-input one-hot selector: round-robin on last owner, or fixed priority
// (requester 0 first) when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`else
  // On a tie the requester that did not own the memory last time wins.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
    else              gnt = req;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two word requesters onto a byte-wide registered memory.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module mem_arbiter #(
  parameter int NREQ   = 2,
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [8*NBYTES-1:0]   wdata0,
  input  logic [8*NBYTES-1:0]   wdata1,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [8*NBYTES-1:0]   rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [1:0]            mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);
  import mem_arb_pkg::*;

  state_e              state;
  logic [CNT_W-1:0]    cnt;
  logic                tail;
  logic                we_q;
  logic [8*NBYTES-1:0] wbuf;
  logic [NREQ-1:0]     sel;
  logic                last_own;
  logic [CNT_W-1:0]    rd_idx;

  rr_arbiter u_arb (
    .req  (req),
    .last (last_own),
    .gnt  (sel)
  );

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign last_own = 1'b1;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           last_own <= 1'b1;
    else if (state == ST_IDLE && |req) last_own <= sel[1];
  end
`endif

  // Byte landing in the current read cycle was addressed one cycle earlier;
  // the tail cycle (cnt held at last) collects the final byte.
  assign rd_idx = tail ? cnt : cnt - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= '0;
      cnt   <= '0;
      tail  <= 1'b0;
      we_q  <= 1'b0;
      wbuf  <= '0;
      rdata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (|req) begin
          gnt   <= sel;
          we_q  <= sel[1] ? we[1] : we[0];
          wbuf  <= sel[1] ? wdata1 : wdata0;
          cnt   <= '0;
          tail  <= 1'b0;
          state <= ST_GRANT;
        end
        ST_GRANT: state <= we_q ? ST_WR : ST_RD;
        ST_WR: begin
          if (cnt == CNT_W'(NBYTES-1)) state <= ST_DONE;
          else                         cnt   <= cnt + 1'b1;
        end
        ST_RD: begin
          if (tail || cnt != '0) rdata[{rd_idx, 3'b000} +: 8] <= mem_rdata;
          if (tail)                          state <= ST_DONE;
          else if (cnt == CNT_W'(NBYTES-1))  tail  <= 1'b1;
          else                               cnt   <= cnt + 1'b1;
        end
        ST_DONE: begin
          gnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = '0;
    case (state)
      ST_WR: begin
        mem_wr    = 1'b1;
        mem_addr  = cnt;
        mem_wdata = wbuf[{cnt, 3'b000} +: 8];
      end
      ST_RD: if (!tail) begin
        mem_rd   = 1'b1;
        mem_addr = cnt;
      end
      ST_DONE: done = gnt;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected
// memory strobes and done pulses; a negedge monitor pops and compares.
module tb_mem_arbiter;

  typedef struct { logic wr; logic [1:0] addr; logic [7:0] data; } mev_t;
  typedef struct { logic [1:0] who; logic rd; logic [31:0] rdata; int lat; } dev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  gnt, done;
  logic [31:0] rdata;
  logic        mem_rd, mem_wr;
  logic [1:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem [4];
  mev_t        exp_mem[$];
  dev_t        exp_done[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  mem_arbiter #(.NREQ(2), .NBYTES(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done(done), .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Registered byte memory: read data appears the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_txn(input logic [1:0] who, input logic wr, input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      mev_t m;
      m.wr = wr; m.addr = 2'(i); m.data = word[8*i +: 8];
      exp_mem.push_back(m);
    end
    begin
      dev_t d;
      d.who = who; d.rd = !wr; d.rdata = word; d.lat = wr ? 6 : 7;
      exp_done.push_back(d);
    end
  endtask

  task automatic wait_dones(input string name, input int n);
    int got = 0;
    for (int c = 0; c < 400 && got < n; c++) begin
      @(negedge clk);
      if (done != 2'b00) got++;
    end
    if (got < n) begin
      total++; bad++;
      $display("FAIL %s timeout: got %0d dones want %0d", name, got, n);
    end
  endtask

  task automatic set_mem(input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[i] = w[8*i +: 8];
  endtask

  always @(negedge clk) begin
    if (rst) cyc = 0;
    else begin
      cyc = (gnt != 2'b00) ? cyc + 1 : 0;
      if (mem_rd || mem_wr) begin
        chk("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
        if (exp_mem.size() == 0) chk("unexpected_strobe", {30'd0, mem_rd, mem_wr}, 32'd0);
        else begin
          mev_t m;
          m = exp_mem.pop_front();
          chk("mem_wr", {31'd0, mem_wr}, {31'd0, m.wr});
          chk("mem_addr", {30'd0, mem_addr}, {30'd0, m.addr});
          if (m.wr) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, m.data});
        end
      end
      if (done != 2'b00) begin
        if (exp_done.size() == 0) chk("unexpected_done", {30'd0, done}, 32'd0);
        else begin
          dev_t d;
          d = exp_done.pop_front();
          chk("done_owner", {30'd0, done}, {30'd0, d.who});
          chk("latency", cyc, d.lat);
          if (d.rd) chk("rdata", rdata, d.rdata);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = 2'b00; we = 2'b00; wdata0 = '0; wdata1 = '0;
    #12;
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_done", {30'd0, done}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_addr_wdata", {22'd0, mem_addr, mem_wdata}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Both requesters held: reads, owners alternate (or stay 0 when fixed).
    set_mem(32'h04030201);
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) push_txn(2'b01, 1'b0, 32'h04030201);
`else
    push_txn(2'b01, 1'b0, 32'h04030201);
    push_txn(2'b10, 1'b0, 32'h04030201);
    push_txn(2'b01, 1'b0, 32'h04030201);
    push_txn(2'b10, 1'b0, 32'h04030201);
`endif
    we = 2'b00; req = 2'b11;
    wait_dones("rr4", 4);
    req = 2'b00;

    // Requester 1 reads 11,22,33,44.
    @(negedge clk);
    set_mem(32'h44332211);
    push_txn(2'b10, 1'b0, 32'h44332211);
    we = 2'b00; req = 2'b10;
    wait_dones("rd1", 1);
    req = 2'b00;

    // Requester 0 writes; rdata must hold across the write.
    @(negedge clk);
    push_txn(2'b01, 1'b1, 32'hA1B2C3D4);
    we = 2'b01; wdata0 = 32'hA1B2C3D4; req = 2'b01;
    wait_dones("wr0", 1);
    req = 2'b00;
    chk("rdata_hold", rdata, 32'h44332211);
    chk("mem_after_wr", {mem[3], mem[2], mem[1], mem[0]}, 32'hA1B2C3D4);

    // Requester 0 drops req mid-write; the write still completes.
    @(negedge clk);
    push_txn(2'b01, 1'b1, 32'h55667788);
    wdata0 = 32'h55667788; req = 2'b01;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_wr && mem_addr == 2'd1) break;
    end
    req = 2'b00;
    wait_dones("wr_drop", 1);

    // Readback by requester 0.
    @(negedge clk);
    push_txn(2'b01, 1'b0, 32'h55667788);
    we = 2'b00; req = 2'b01;
    wait_dones("rd_back", 1);
    req = 2'b00;

    // Reset in the RD cycle with cnt=2: only addr 0..2 strobes, no done.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mev_t m;
      m.wr = 1'b0; m.addr = 2'(i); m.data = 8'h00;
      exp_mem.push_back(m);
    end
    req = 2'b10;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 2'd2) break;
    end
    #1 rst = 1'b1;
    #1;
    chk("abort_gnt", {30'd0, gnt}, 32'd0);
    chk("abort_done", {30'd0, done}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("abort_addr", {30'd0, mem_addr}, 32'd0);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Clean read after the abort.
    @(negedge clk);
    push_txn(2'b10, 1'b0, 32'h55667788);
    req = 2'b10;
    wait_dones("rd_after_rst", 1);
    req = 2'b00;

    repeat (4) @(negedge clk);
    chk("mem_q_empty", exp_mem.size(), 32'd0);
    chk("done_q_empty", exp_done.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters; only the value 2 is supported.
REQ-002 Parameter NBYTES, default 4, bytes per word and depth of the downstream byte memory.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req  in  2  per-requester request level; the requester holds it until its done pulse.
REQ-007 we  in  2  per-requester op select (1=write word, 0=read word); sampled at grant.
REQ-008 wdata0, wdata1  in  32  per-requester write word; sampled at grant.
REQ-009 gnt  out  2  one-hot owner of the memory; 0 when idle.
REQ-010 done  out  2  one-cycle completion pulse to the owner.
REQ-011 rdata  out  32  assembled read word; valid when done is high for a read.
REQ-012 mem_rd, mem_wr  out  1 each  downstream byte read/write strobes; never both high.
REQ-013 mem_addr  out  2  downstream byte address.
REQ-014 mem_wdata  out  8  downstream write byte.
REQ-015 mem_rdata  in  8  downstream read byte; registered, valid the cycle after mem_rd.

Function
REQ-016 The FSM SHALL have the states IDLE, GRANT, WR, RD, DONE.
REQ-017 IDLE: when req is nonzero, select the winner, register gnt, latch we/wdata, and clear the byte counter cnt; next state GRANT.
REQ-018 GRANT: one cycle with no strobes; next state is WR if the latched we=1, else RD.
REQ-019 WR: mem_wr=1, mem_addr=cnt, mem_wdata=latched word byte[cnt] (byte 0=[7:0]); cnt increments per cycle; after cnt=3, go to DONE (4 cycles total).
REQ-020 RD: mem_rd=1, mem_addr=cnt for cnt 0..3 (4 cycles); mem_rdata is captured into rdata byte[cnt-1] on the following cycle; the fifth cycle captures byte 3 with mem_rd=0, then goes to DONE.
REQ-021 DONE: done[owner]=1 for exactly one cycle, rdata stable; gnt clears on the next edge; return to IDLE.
REQ-022 Latency from grant to done is 6 cycles for a write and 7 cycles for a read.
REQ-023 Default arbitration is round-robin: on simultaneous requests the requester that was not the last owner wins; after reset the last owner is 1, so requester 0 wins first.
REQ-024 A req deasserted mid-transaction SHALL be ignored; the transaction completes.
REQ-025 A request arriving during a transaction waits; no preemption.
REQ-026 The counter cnt is 2 bits and wraps only via state exit, never mid-operation.
REQ-027 rdata holds its last value through writes and idle periods.

Reset
REQ-028 rst asynchronously forces the FSM to IDLE, gnt=0, done=0, rdata=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, cnt=0, last owner=1.
REQ-029 Reset during WR or RD aborts the transaction with no done pulse; a partial memory write is acceptable.

Configuration
REQ-030 With the macro MEM_ARB_FIXED_PRIO_EN defined, arbitration is fixed priority and requester 0 always wins a tie.
REQ-031 Without MEM_ARB_FIXED_PRIO_EN, arbitration is round-robin per REQ-023; the last-owner register exists only in this build.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the FSM state enum, NBYTES=4, and the byte-index width constant.
REQ-033 A sub-module rr_arbiter (2-input, one-hot grant, last-owner input) SHALL implement the selection, including the fixed-priority variant under the macro.

Verification
REQ-034 Scenario: req=01, we0=1, wdata0=32'hA1B2C3D4 -> mem_wr on 4 consecutive cycles with addr 0..3 and bytes D4,C3,B2,A1; done=01 six cycles after grant.
REQ-035 Scenario: req=10, we1=0, memory model holds 11,22,33,44 at addr 0..3 -> rdata=32'h44332211 with done=10 seven cycles after grant.
REQ-036 Scenario: req=11 held continuously, default build -> grants alternate 01,10,01,10.
REQ-037 Scenario: the same stimulus with MEM_ARB_FIXED_PRIO_EN defined -> gnt stays 01 for every grant.
REQ-038 Scenario: rst asserted during the cycle with RD cnt=2 -> all outputs are 0 immediately, no done pulse, and the next request starts a clean 7-cycle read.
REQ-039 Scenario: req0 drops during WR -> the write still completes all 4 bytes and done=01 pulses.
